// File: rtl/circuit_bist_pkg.sv
// Shared types and golden reference for the 3-in/2-out logic circuit BIST.
package circuit_bist_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } bist_state_e;

  localparam logic [2:0] VEC_LAST = 3'd7;

  // Golden response {d,e} for stimulus vector {a,b,c}.
  function automatic logic [1:0] exp_de(input logic [2:0] vec);
    logic a, b, c;
    {a, b, c} = vec;
    return {(a & b) | ~c, ~c};
  endfunction

endpackage

// File: rtl/circuit_golden_model.sv
// Combinational golden model of the circuit under test: {d,e} from {a,b,c}.
module circuit_golden_model
  import circuit_bist_pkg::*;
(
  input  logic [2:0] vec_i,
  output logic [1:0] de_o
);

  assign de_o = exp_de(vec_i);

endmodule

// File: rtl/circuit_bist_ctrl.sv
// BIST sequencer: walks all eight {a,b,c} vectors through the circuit under
// test, samples {d,e} after a settle time and reports pass/fail results.
module circuit_bist_ctrl
  import circuit_bist_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned CNT_W         = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic       a_o,
  output logic       b_o,
  output logic       c_o,
  input  logic       d_i,
  input  logic       e_i,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [2:0] fail_vec,
  output logic       fail_valid
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  bist_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       vec_q, vec_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [3:0]       err_q, err_d;
  logic [2:0]       fail_vec_q, fail_vec_d;
  logic             fail_valid_q, fail_valid_d;

  logic [1:0]       exp_de_w;
  logic             mismatch;

  circuit_golden_model u_golden (
    .vec_i (vec_q),
    .de_o  (exp_de_w)
  );

  assign mismatch = ({d_i, e_i} != exp_de_w);

  always_comb begin
    // NOTE: every _d gets a hold/default value first so no path through the
    // case statement leaves a signal unassigned, which would infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    vec_d        = vec_q;
    done_d       = 1'b0;
    pass_d       = pass_q;
    err_d        = err_q;
    fail_vec_d   = fail_vec_q;
    fail_valid_d = fail_valid_q;

    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d      = SETTLE;
          vec_d        = '0;
          cnt_d        = CNT_LOAD;
          err_d        = '0;
          fail_vec_d   = '0;
          fail_valid_d = 1'b0;
          pass_d       = 1'b0;
        end
      end

      SETTLE: begin
        if (abort) begin
          state_d = IDLE;
          vec_d   = '0;
          pass_d  = 1'b0;
        end else if (cnt_q == '0) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      SAMPLE: begin
        // A mismatch seen in this cycle is recorded even if abort is also set.
        if (mismatch) begin
          err_d = err_q + 4'd1;
          if (!fail_valid_q) begin
            fail_vec_d   = vec_q;
            fail_valid_d = 1'b1;
          end
        end
        if (abort) begin
          state_d = IDLE;
          vec_d   = '0;
          pass_d  = 1'b0;
        end else if (vec_q == VEC_LAST) begin
          // NOTE: blocking '=' inside always_comb lets pass_d see the err_d
          // just computed above, so the last vector's result is included.
          state_d = DONE;
          vec_d   = '0;
          done_d  = 1'b1;
          pass_d  = (err_d == 4'd0);
        end else begin
          state_d = SETTLE;
          vec_d   = vec_q + 3'd1;
          cnt_d   = CNT_LOAD;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == SETTLE) || (state_d == SAMPLE);
  end

  // NOTE: sequential state uses non-blocking '<=' so all registers update
  // together from values sampled at the same clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      vec_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_q        <= '0;
      fail_vec_q   <= '0;
      fail_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      vec_q        <= vec_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      err_q        <= err_d;
      fail_vec_q   <= fail_vec_d;
      fail_valid_q <= fail_valid_d;
    end
  end

  assign {a_o, b_o, c_o} = vec_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_count       = err_q;
  assign fail_vec        = fail_vec_q;
  assign fail_valid      = fail_valid_q;

endmodule

// File: tb/tb_circuit_bist_ctrl.sv
// Scoreboard bench: two sequencers (settle 1 and 3) share start/abort/reset,
// each driving its own faultable circuit model.
module tb_circuit_bist_ctrl;

  localparam int S0 = 1;
  localparam int S1 = 3;

  typedef struct {
    int cyc;
    int pass;
    int err;
    int fv;
    int fvec;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [1:0] a_o, b_o, c_o, d_i, e_i, busy, done, pass, fail_valid;
  logic [3:0] err_count [2];
  logic [2:0] fail_vec [2];

  // Per-vector fault masks: bit v flips d (or e) while vector v is applied.
  logic [7:0] fd = '0;
  logic [7:0] fe = '0;
  logic       rnd_mode = 1'b0;
  logic [1:0] rnd_d = '0;
  logic [1:0] rnd_e = '0;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   done_cnt [2] = '{0, 0};
  int   start_cyc [2] = '{0, 0};
  logic active [2] = '{1'b0, 1'b0};
  exp_t sb0 [$];
  exp_t sb1 [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int s_of(input int k);
    return (k == 0) ? S0 : S1;
  endfunction

  function automatic logic good_d(input logic [2:0] v);
    return (v[2] && v[1]) || !v[0];
  endfunction

  function automatic logic good_e(input logic [2:0] v);
    return !v[0];
  endfunction

  assign d_i[0] = rnd_mode ? rnd_d[0] : good_d({a_o[0], b_o[0], c_o[0]}) ^ fd[{a_o[0], b_o[0], c_o[0]}];
  assign e_i[0] = rnd_mode ? rnd_e[0] : good_e({a_o[0], b_o[0], c_o[0]}) ^ fe[{a_o[0], b_o[0], c_o[0]}];
  assign d_i[1] = rnd_mode ? rnd_d[1] : good_d({a_o[1], b_o[1], c_o[1]}) ^ fd[{a_o[1], b_o[1], c_o[1]}];
  assign e_i[1] = rnd_mode ? rnd_e[1] : good_e({a_o[1], b_o[1], c_o[1]}) ^ fe[{a_o[1], b_o[1], c_o[1]}];

  circuit_bist_ctrl #(.SETTLE_CYCLES(S0), .CNT_W(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .a_o(a_o[0]), .b_o(b_o[0]), .c_o(c_o[0]), .d_i(d_i[0]), .e_i(e_i[0]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_count(err_count[0]),
    .fail_vec(fail_vec[0]), .fail_valid(fail_valid[0])
  );

  circuit_bist_ctrl #(.SETTLE_CYCLES(S1), .CNT_W(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .a_o(a_o[1]), .b_o(b_o[1]), .c_o(c_o[1]), .d_i(d_i[1]), .e_i(e_i[1]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_count(err_count[1]),
    .fail_vec(fail_vec[1]), .fail_valid(fail_valid[1])
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: the first n vectors are sampled; a vector fails if either
  // output is flipped while it is applied.
  task automatic ref_run(input int n, output int err, output int fv, output int fvec);
    err = 0; fv = 0; fvec = 0;
    for (int v = 0; v < n; v++) begin
      if (fd[v] || fe[v]) begin
        if (fv == 0) begin
          fv = 1;
          fvec = v;
        end
        err++;
      end
    end
  endtask

  // Monitor: pops an expectation on every done pulse; while a run is active
  // it also checks the stimulus walk and busy.
  int   mon_rel;
  exp_t mon_e;
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (done[k]) begin
        if ((k == 0 && sb0.size() == 0) || (k == 1 && sb1.size() == 0)) begin
          check($sformatf("unexpected_done_dut%0d", k), int'(done[k]), 0);
        end else begin
          mon_e = (k == 0) ? sb0.pop_front() : sb1.pop_front();
          check($sformatf("done_cycle_dut%0d", k), cyc, mon_e.cyc);
          check($sformatf("pass_dut%0d", k), int'(pass[k]), mon_e.pass);
          check($sformatf("err_count_dut%0d", k), int'(err_count[k]), mon_e.err);
          check($sformatf("fail_valid_dut%0d", k), int'(fail_valid[k]), mon_e.fv);
          if (mon_e.fv != 0)
            check($sformatf("fail_vec_dut%0d", k), int'(fail_vec[k]), mon_e.fvec);
          check($sformatf("done_stim_dut%0d", k), int'({a_o[k], b_o[k], c_o[k]}), 0);
          check($sformatf("done_busy_dut%0d", k), int'(busy[k]), 0);
        end
        done_cnt[k]++;
      end
      if (active[k]) begin
        mon_rel = cyc - start_cyc[k];
        if (mon_rel < 8 * (s_of(k) + 1)) begin
          check($sformatf("stim_dut%0d", k), int'({a_o[k], b_o[k], c_o[k]}), mon_rel / (s_of(k) + 1));
          check($sformatf("busy_dut%0d", k), int'(busy[k]), 1);
        end
      end
    end
  end

  // All stimulus tasks are entered and left 1 time unit after a rising edge.
  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      start_cyc[k] = cyc;
      active[k] = 1'b1;
    end
  endtask

  task automatic run_full(input logic [7:0] fd_in, input logic [7:0] fe_in, input bit mid_start);
    int   tgt [2];
    exp_t e;
    fd = fd_in;
    fe = fe_in;
    for (int k = 0; k < 2; k++) begin
      tgt[k] = done_cnt[k] + 1;
      ref_run(8, e.err, e.fv, e.fvec);
      e.pass = (e.err == 0) ? 1 : 0;
      e.cyc = cyc + 1 + 8 * (s_of(k) + 1);
      if (k == 0) sb0.push_back(e);
      else        sb1.push_back(e);
    end
    do_start();
    if (mid_start) begin
      repeat ($urandom_range(1, 12)) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
    end
    for (int i = 0; i < 100 && (done_cnt[0] < tgt[0] || done_cnt[1] < tgt[1]); i++)
      @(posedge clk);
    #1;
    check("run_complete_dut0", done_cnt[0], tgt[0]);
    check("run_complete_dut1", done_cnt[1], tgt[1]);
    active[0] = 1'b0;
    active[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Abort t cycles after the start edge (t below 16 keeps both runs busy).
  task automatic run_abort(input logic [7:0] fd_in, input logic [7:0] fe_in, input int t);
    int err [2];
    int fv [2];
    int fvec [2];
    int s, n;
    fd = fd_in;
    fe = fe_in;
    do_start();
    repeat (t) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      s = s_of(k);
      n = t / (s + 1) + ((t % (s + 1) == s) ? 1 : 0);
      ref_run(n, err[k], fv[k], fvec[k]);
    end
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    active[0] = 1'b0;
    active[1] = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("abort_busy_dut%0d", k), int'(busy[k]), 0);
      check($sformatf("abort_stim_dut%0d", k), int'({a_o[k], b_o[k], c_o[k]}), 0);
      check($sformatf("abort_pass_dut%0d", k), int'(pass[k]), 0);
      check($sformatf("abort_err_dut%0d", k), int'(err_count[k]), err[k]);
      check($sformatf("abort_fv_dut%0d", k), int'(fail_valid[k]), fv[k]);
      if (fv[k] != 0)
        check($sformatf("abort_fvec_dut%0d", k), int'(fail_vec[k]), fvec[k]);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int k = 0; k < 2; k++)
      check($sformatf("%s_dut%0d", tag, k),
            int'({a_o[k], b_o[k], c_o[k], busy[k], done[k], pass[k], fail_valid[k],
                  err_count[k], fail_vec[k]}), 0);
  endtask

  logic [7:0] d_sa1, e_sa0;

  initial begin
    for (int v = 0; v < 8; v++) begin
      d_sa1[v] = !good_d(3'(v));
      e_sa0[v] = good_e(3'(v));
    end

    // Reset held with random inputs.
    rnd_mode = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      start = 1'($urandom_range(0, 1));
      abort = 1'($urandom_range(0, 1));
      rnd_d = 2'($urandom_range(0, 3));
      rnd_e = 2'($urandom_range(0, 3));
      #1 check_reset_outputs("reset_out");
    end
    rnd_mode = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("idle_after_reset_busy0", int'(busy[0]), 0);
      check("idle_after_reset_busy1", int'(busy[1]), 0);
    end

    run_full(8'h00, 8'h00, 1'b0);   // fault-free
    run_full(d_sa1, 8'h00, 1'b0);   // d stuck-at-1
    run_full(8'h00, e_sa0, 1'b0);   // e stuck-at-0
    run_abort(d_sa1, 8'h00, 8);     // abort at vector 100 (settle of 1)
    run_full(d_sa1, 8'h00, 1'b0);   // restart after abort
    run_full(8'h00, 8'h00, 1'b1);   // start pulse mid-run ignored

    // Reset asserted mid-run clears everything at once.
    fd = 8'($urandom);
    do_start();
    repeat ($urandom_range(1, 15)) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("midrun_reset");
    active[0] = 1'b0;
    active[1] = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // abort and start together in IDLE: no run.
    @(posedge clk);
    #1 start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    abort = 1'b0;
    repeat (3) begin
      check("abort_start_busy0", int'(busy[0]), 0);
      check("abort_start_busy1", int'(busy[1]), 0);
      @(posedge clk);
      #1;
    end

    // Randomized fault patterns, aborts and mid-run starts.
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 3) == 0)
        run_abort(8'($urandom & $urandom), 8'($urandom & $urandom), $urandom_range(0, 15));
      else
        run_full(8'($urandom & $urandom & $urandom), 8'($urandom & $urandom & $urandom),
                 1'($urandom_range(0, 1)));
    end

    check("scoreboard_empty_dut0", sb0.size(), 0);
    check("scoreboard_empty_dut1", sb1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
